// File: rtl/sargantana_icache_way_arbiter_if.sv
// Bundle of the icache-side request/response signals and the way SRAM pins
// seen by the way arbiter.
interface sargantana_icache_way_arbiter_if #(
  parameter int SET_WIDHT  = 256,
  parameter int ADDR_WIDHT = 6
);
  logic                  flush_i;
  logic                  flush_done_o;
  logic                  busy_o;
  logic                  fetch_req_i;
  logic [ADDR_WIDHT-1:0] fetch_addr_i;
  logic                  fetch_gnt_o;
  logic                  fetch_rvalid_o;
  logic [SET_WIDHT-1:0]  fetch_rdata_o;
  logic                  refill_req_i;
  logic [ADDR_WIDHT-1:0] refill_addr_i;
  logic [SET_WIDHT-1:0]  refill_data_i;
  logic                  refill_gnt_o;
  logic                  sram_req_o;
  logic                  sram_we_o;
  logic [ADDR_WIDHT-1:0] sram_addr_o;
  logic [SET_WIDHT-1:0]  sram_data_o;
  logic [SET_WIDHT-1:0]  sram_data_i;

  modport slave (
    input  flush_i, fetch_req_i, fetch_addr_i, refill_req_i, refill_addr_i,
           refill_data_i, sram_data_i,
    output flush_done_o, busy_o, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
           refill_gnt_o, sram_req_o, sram_we_o, sram_addr_o, sram_data_o
  );

  modport master (
    output flush_i, fetch_req_i, fetch_addr_i, refill_req_i, refill_addr_i,
           refill_data_i, sram_data_i,
    input  flush_done_o, busy_o, fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
           refill_gnt_o, sram_req_o, sram_we_o, sram_addr_o, sram_data_o
  );
endinterface

// File: rtl/sargantana_icache_way_arbiter.sv
// Single-port icache way SRAM sequencer: refill/fetch arbitration with fetch
// starvation guard, plus a full-way zeroing sweep on flush.
module sargantana_icache_way_arbiter #(
  parameter int SET_WIDHT  = 256,
  parameter int ADDR_WIDHT = 6,
  parameter int MAX_STALL  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  sargantana_icache_way_arbiter_if.slave bus
);

  localparam logic [0:0]            ST_IDLE   = 1'b0;
  localparam logic [0:0]            ST_FLUSH  = 1'b1;
  localparam logic [3:0]            STALL_MAX = 4'(MAX_STALL);
  localparam logic [ADDR_WIDHT-1:0] LAST_SET  = {ADDR_WIDHT{1'b1}};

  logic [0:0]            state_r;
  logic [ADDR_WIDHT:0]   sweep_cnt_r;
  logic [3:0]            stall_cnt_r;
  logic                  fetch_rvalid_r;
  logic                  flush_done_r;

  logic                  fetch_gnt_s;
  logic                  refill_gnt_s;
  logic                  force_fetch_s;
  logic                  sweep_last_s;
  logic [3:0]            stall_nxt_s;
  logic                  sram_req_s;
  logic                  sram_we_s;
  logic [ADDR_WIDHT-1:0] sram_addr_s;
  logic [SET_WIDHT-1:0]  sram_data_s;

  assign force_fetch_s = bus.fetch_req_i && (stall_cnt_r == STALL_MAX);
  // The MSB can never be set in normal operation; treating it as terminal keeps a corrupted counter from running away.
  assign sweep_last_s  = (sweep_cnt_r[ADDR_WIDHT-1:0] == LAST_SET) || sweep_cnt_r[ADDR_WIDHT];

  // Same-cycle grant: refill first unless fetch has been starved MAX_STALL times
  always_comb begin
    fetch_gnt_s  = 1'b0;
    refill_gnt_s = 1'b0;
    if (rst_i || (state_r == ST_FLUSH)) begin
      fetch_gnt_s  = 1'b0;
      refill_gnt_s = 1'b0;
    end else if (force_fetch_s) begin
      fetch_gnt_s = 1'b1;
    end else if (bus.refill_req_i) begin
      refill_gnt_s = 1'b1;
    end else if (bus.fetch_req_i) begin
      fetch_gnt_s = 1'b1;
    end else begin
      fetch_gnt_s  = 1'b0;
      refill_gnt_s = 1'b0;
    end
  end

  // SRAM pin mux: sweep write, fetch read, refill write, or idle
  always_comb begin
    sram_req_s  = 1'b0;
    sram_we_s   = 1'b0;
    sram_addr_s = bus.fetch_addr_i;
    sram_data_s = bus.refill_data_i;
    if (!rst_i && (state_r == ST_FLUSH)) begin
      sram_req_s  = 1'b1;
      sram_we_s   = 1'b1;
      sram_addr_s = sweep_cnt_r[ADDR_WIDHT-1:0];
      sram_data_s = {SET_WIDHT{1'b0}};
    end else if (fetch_gnt_s) begin
      sram_req_s  = 1'b1;
      sram_we_s   = 1'b0;
      sram_addr_s = bus.fetch_addr_i;
    end else if (refill_gnt_s) begin
      sram_req_s  = 1'b1;
      sram_we_s   = 1'b1;
      sram_addr_s = bus.refill_addr_i;
      sram_data_s = bus.refill_data_i;
    end else begin
      sram_req_s = 1'b0;
      sram_we_s  = 1'b0;
    end
  end

  // Fetch starvation count: grows only when a waiting fetch loses to refill
  always_comb begin
    stall_nxt_s = stall_cnt_r;
    if (fetch_gnt_s || !bus.fetch_req_i) begin
      stall_nxt_s = 4'd0;
    end else if (refill_gnt_s && (stall_cnt_r < STALL_MAX)) begin
      stall_nxt_s = stall_cnt_r + 4'd1;
    end else begin
      stall_nxt_s = stall_cnt_r;
    end
  end

  // Sweep FSM, stall counter and registered response strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= ST_IDLE;
      sweep_cnt_r    <= {(ADDR_WIDHT+1){1'b0}};
      stall_cnt_r    <= 4'd0;
      fetch_rvalid_r <= 1'b0;
      flush_done_r   <= 1'b0;
    end else begin
      fetch_rvalid_r <= fetch_gnt_s;
      flush_done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          stall_cnt_r <= stall_nxt_s;
          if (bus.flush_i) begin
            state_r     <= ST_FLUSH;
            sweep_cnt_r <= {(ADDR_WIDHT+1){1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (sweep_last_s) begin
            state_r      <= ST_IDLE;
            sweep_cnt_r  <= {(ADDR_WIDHT+1){1'b0}};
            flush_done_r <= 1'b1;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + {{ADDR_WIDHT{1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          sweep_cnt_r <= {(ADDR_WIDHT+1){1'b0}};
        end
      endcase
    end
  end

  assign bus.fetch_gnt_o    = fetch_gnt_s;
  assign bus.refill_gnt_o   = refill_gnt_s;
  assign bus.fetch_rvalid_o = fetch_rvalid_r;
  assign bus.fetch_rdata_o  = bus.sram_data_i;
  assign bus.flush_done_o   = flush_done_r;
  assign bus.busy_o         = (state_r == ST_FLUSH);
  assign bus.sram_req_o     = sram_req_s;
  assign bus.sram_we_o      = sram_we_s;
  assign bus.sram_addr_o    = sram_addr_s;
  assign bus.sram_data_o    = sram_data_s;

endmodule

// File: tb/tb_sargantana_icache_way_arbiter.sv
// Bench for the icache way arbiter: a behavioural SRAM plus a cycle-level
// reference model of grants, sweep progress and expected read contents.
module tb_sargantana_icache_way_arbiter;

  localparam int SW    = 256;
  localparam int AW    = 6;
  localparam int NSETS = 64;
  localparam int MAXS  = 4;

  logic clk;
  logic rst;
  logic mem_init;
  int   total;
  int   bad;

  sargantana_icache_way_arbiter_if #(.SET_WIDHT(SW), .ADDR_WIDHT(AW)) bus ();

  sargantana_icache_way_arbiter #(.SET_WIDHT(SW), .ADDR_WIDHT(AW), .MAX_STALL(MAXS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] pat(input int i);
    logic [SW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = (32'(i) * 32'h9E37_79B9) ^ (32'h0101_0101 * 32'(k + 1));
    return v;
  endfunction

  function automatic logic [SW-1:0] rnd256();
    logic [SW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Behavioural single-port SRAM with 1-cycle read latency
  logic [SW-1:0] mem [NSETS];
  logic [SW-1:0] rd_q;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NSETS; i++) mem[i] <= pat(i);
      rd_q <= '0;
    end else if (bus.sram_req_o) begin
      if (bus.sram_we_o) mem[bus.sram_addr_o] <= bus.sram_data_o;
      else               rd_q <= mem[bus.sram_addr_o];
    end
  end
  assign bus.sram_data_i = rd_q;

  // Reference model state
  logic [SW-1:0] exp_mem [NSETS];
  int            m_busy, m_idx, m_stall;
  logic          m_rv, m_done;
  logic [SW-1:0] m_rd;
  logic          s_fg, s_rg, s_req, s_we, s_done, s_busy;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_data;

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_stall = 0; m_rv = 1'b0; m_done = 1'b0; m_rd = '0;
  endtask

  // One clock cycle: drive, check against the model, advance the model
  task automatic step(input logic f, input logic fr, input logic [AW-1:0] fa,
                      input logic rr, input logic [AW-1:0] ra, input logic [SW-1:0] rd);
    logic e_fg, e_rg, e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_data;
    bus.flush_i = f; bus.fetch_req_i = fr; bus.fetch_addr_i = fa;
    bus.refill_req_i = rr; bus.refill_addr_i = ra; bus.refill_data_i = rd;
    #1;
    if (m_busy != 0) begin
      e_fg = 1'b0; e_rg = 1'b0; e_req = 1'b1; e_we = 1'b1;
      e_addr = AW'(m_idx); e_data = '0;
    end else begin
      e_fg   = fr && ((m_stall == MAXS) || !rr);
      e_rg   = rr && !e_fg;
      e_req  = e_fg || e_rg;
      e_we   = e_rg;
      e_addr = e_fg ? fa : ra;
      e_data = rd;
    end
    s_fg = bus.fetch_gnt_o; s_rg = bus.refill_gnt_o; s_req = bus.sram_req_o;
    s_we = bus.sram_we_o; s_addr = bus.sram_addr_o; s_data = bus.sram_data_o;
    s_done = bus.flush_done_o; s_busy = bus.busy_o;
    chk("fetch_gnt", SW'(s_fg), SW'(e_fg));
    chk("refill_gnt", SW'(s_rg), SW'(e_rg));
    chk("sram_req", SW'(s_req), SW'(e_req));
    chk("busy", SW'(s_busy), SW'(m_busy != 0));
    chk("rvalid", SW'(bus.fetch_rvalid_o), SW'(m_rv));
    chk("flush_done", SW'(s_done), SW'(m_done));
    if (e_req) begin
      chk("sram_we", SW'(s_we), SW'(e_we));
      chk("sram_addr", SW'(s_addr), SW'(e_addr));
    end
    if (e_req && e_we) chk("sram_wdata", s_data, e_data);
    if (m_rv) chk("rdata", bus.fetch_rdata_o, m_rd);
    @(posedge clk);
    if (e_fg) m_rd = exp_mem[fa];
    if (m_busy != 0) exp_mem[m_idx] = '0;
    else if (e_rg) exp_mem[ra] = rd;
    m_rv = e_fg;
    m_done = 1'b0;
    if (m_busy != 0) begin
      if (m_idx == NSETS - 1) begin m_busy = 0; m_idx = 0; m_done = 1'b1; end
      else m_idx++;
    end else begin
      if (f) begin m_busy = 1; m_idx = 0; end
      if (e_fg || !fr) m_stall = 0;
      else if (e_rg && m_stall < MAXS) m_stall++;
    end
    @(negedge clk);
  endtask

  initial begin
    int done_cnt, zero_wr;
    total = 0; bad = 0;
    rst = 1'b1; mem_init = 1'b1;
    bus.flush_i = 1'b0; bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 6'd1;
    bus.refill_req_i = 1'b1; bus.refill_addr_i = 6'd2; bus.refill_data_i = '1;
    for (int i = 0; i < NSETS; i++) exp_mem[i] = pat(i);
    model_reset();
    @(posedge clk); @(negedge clk);
    mem_init = 1'b0;
    chk("rst_fetch_gnt", SW'(bus.fetch_gnt_o), SW'(1'b0));
    chk("rst_refill_gnt", SW'(bus.refill_gnt_o), SW'(1'b0));
    chk("rst_sram_req", SW'(bus.sram_req_o), SW'(1'b0));
    chk("rst_sram_we", SW'(bus.sram_we_o), SW'(1'b0));
    chk("rst_busy", SW'(bus.busy_o), SW'(1'b0));
    chk("rst_rvalid", SW'(bus.fetch_rvalid_o), SW'(1'b0));
    chk("rst_done", SW'(bus.flush_done_o), SW'(1'b0));
    rst = 1'b0;

    // Plain fetch at set 5 and its read-back one cycle later
    step(1'b0, 1'b1, 6'd5, 1'b0, 6'd0, '0);
    chk("fetch5_gnt", SW'(s_fg), SW'(1'b1));
    chk("fetch5_addr", SW'(s_addr), SW'(6'd5));
    chk("fetch5_we", SW'(s_we), SW'(1'b0));
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, '0);
    chk("fetch5_data", bus.fetch_rdata_o, pat(5));

    // Continuous contention: four refills then one forced fetch, repeating
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b1, AW'(k), 1'b1, AW'(k + 20), rnd256());
      chk("contend_fetch", SW'(s_fg), SW'((k % 5) == 4));
      chk("contend_refill", SW'(s_rg), SW'((k % 5) != 4));
    end
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, '0);

    // Flush with a fetch granted in the same cycle, second pulse ignored
    step(1'b1, 1'b1, 6'd7, 1'b0, 6'd0, '0);
    chk("flushcyc_fetch_gnt", SW'(s_fg), SW'(1'b1));
    done_cnt = 0; zero_wr = 0;
    for (int i = 0; i < 67; i++) begin
      step(i == 10, 1'b1, 6'd9, 1'b1, 6'd12, rnd256());
      if (s_done) done_cnt++;
      if (s_busy && s_req && s_we && s_data == '0) zero_wr++;
      if (i < NSETS) begin
        chk("sweep_addr", SW'(s_addr), SW'(i));
        chk("sweep_no_gnt", SW'(s_fg | s_rg), SW'(1'b0));
      end
      if (i == 64) chk("sweep_done_cycle", SW'(s_done), SW'(1'b1));
    end
    chk("sweep_done_count", SW'(done_cnt), SW'(1));
    chk("sweep_zero_writes", SW'(zero_wr), SW'(NSETS));
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, AW'(i * 11), 1'b0, 6'd0, '0);

    // Randomized traffic with rare flushes
    for (int n = 0; n < 350; n++)
      step($urandom_range(0, 149) == 0, 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), rnd256());
    while (m_busy != 0) step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, '0);
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, '0);

    // Reset in the middle of a sweep
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, '0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, '0);
    chk("midrst_sweep_idx", SW'(s_addr), SW'(6'd19));
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 6'd30;
    rst = 1'b1;
    #1;
    chk("midrst_busy", SW'(bus.busy_o), SW'(1'b0));
    chk("midrst_sram_req", SW'(bus.sram_req_o), SW'(1'b0));
    chk("midrst_fetch_gnt", SW'(bus.fetch_gnt_o), SW'(1'b0));
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    done_cnt = 0;
    step(1'b0, 1'b1, 6'd30, 1'b0, 6'd0, '0);
    if (s_done) done_cnt++;
    chk("postrst_fetch_gnt", SW'(s_fg), SW'(1'b1));
    step(1'b0, 1'b1, 6'd3, 1'b0, 6'd0, '0);
    if (s_done) done_cnt++;
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, '0);
    if (s_done) done_cnt++;
    chk("postrst_set3_zero", bus.fetch_rdata_o, '0);
    chk("postrst_no_done", SW'(done_cnt), SW'(0));

    for (int n = 0; n < 200; n++)
      step($urandom_range(0, 199) == 0, 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), rnd256());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
